mem_dsram_ctrl: RTL and testbench
=================================

Name: mem_dsram_ctrl

Overview:
- Data-memory access controller sitting between the EX/MEM pipeline stages and the single data SRAM-like port (req/addr_ok/data_ok).
- Shares the port between two requesters: stores issued from EX, and loads held by MEM via its read_data_req / read_data_out_req handshake.
- Sequences one transaction at a time, holds returned load data until MEM advances, and drops in-flight load responses on excp_flush/ertn_flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ld_req  in  1  load request level from MEM (MEM valid and is_ld)
ld_addr  in  ADDR_W  load address (alu_result)
ld_size  in  2  0=byte, 1=half, 2=word
ld_fire  in  1  MEM stage advancing this cycle (MEM_to_WB_valid && WB_allow_in)
ld_data_ok  out  1  load data valid, level (drives read_data_out_req)
ld_rdata  out  DATA_W  raw word returned; MEM does byte/half extraction
st_req  in  1  store request from EX, already gated by requester with no_we / flush
st_addr  in  ADDR_W  store address
st_wstrb  in  4  byte enables
st_wdata  in  DATA_W  store data
st_accept  out  1  one-cycle pulse: store taken by memory (addr_ok); EX may advance
flush  in  1  excp_flush | ertn_flush
mem_req  out  1  memory request
mem_wr  out  1  1=write
mem_size  out  2  access size
mem_addr  out  ADDR_W  address
mem_wstrb  out  4  write strobes (0 for reads)
mem_wdata  out  DATA_W  write data
mem_addr_ok  in  1  request accepted
mem_data_ok  in  1  response/write done
mem_rdata  in  DATA_W  read data

Behaviour:
- One clock, synchronous active-high reset. Reset forces state IDLE, ld_rdata=0, and all mem_* outputs, ld_data_ok and st_accept to 0.
- States: IDLE, REQ, WAIT_DATA, HOLD, DISCARD. At most one outstanding transaction.
- IDLE: sample requests at the clock edge. Priority: ld_req over st_req, because the load in MEM is older than the store in EX.
  - On a grant, latch mem_wr, mem_size, mem_addr, mem_wstrb and mem_wdata (wstrb=0 for loads) and go to REQ.
  - mem_req therefore rises one cycle after the request is seen.
  - Flush asserted in IDLE: grant nothing and stay in IDLE.
- REQ: mem_req=1 with all mem_* fields stable.
  - The request is never retracted before mem_addr_ok, even on flush.
  - On mem_addr_ok: go to WAIT_DATA. If the access is a store, pulse st_accept in that same cycle (combinational from REQ && mem_addr_ok && mem_wr).
  - A load with flush seen in REQ (or flush coincident with addr_ok) sets a kill flag; the load then goes to DISCARD after addr_ok instead of WAIT_DATA.
- WAIT_DATA: mem_req=0.
  - On mem_data_ok, load: capture mem_rdata into ld_rdata and go to HOLD.
  - On mem_data_ok, store: go to IDLE.
  - Flush while a load is in WAIT_DATA: go to DISCARD. If flush and mem_data_ok coincide: go to IDLE and drop the data.
  - Stores ignore flush after acceptance (the write is architecturally committed).
- HOLD: ld_data_ok=1 and ld_rdata stable.
  - ld_fire → IDLE.
  - flush → IDLE.
  - Otherwise stay (covers a WB stall).
  - A new request is never sampled in the same cycle as leaving HOLD, so there is a one-cycle bubble between back-to-back loads.
- DISCARD: wait for mem_data_ok, then go to IDLE. ld_data_ok stays 0 and the response is dropped.
- ld_data_ok = (state==HOLD), registered. Minimum load latency is ld_req → ld_data_ok in 3 cycles, given addr_ok in the first REQ cycle and data_ok on the next cycle.
- mem_size for loads = ld_size; for stores = 2'b10 when st_wstrb==4'hF, 2'b01 for two-bit strobes, 2'b00 otherwise.
- ld_req dropping while in REQ/WAIT_DATA (only legal via flush) has no effect other than the flush rules.
- Reset mid-transaction: the block returns to IDLE immediately; the memory side is reset together with it.

Test Plan:
- Load, no stall: ld_req=1, ld_addr=0x1C00_0010, ld_size=2; addr_ok in the first REQ cycle, data_ok next cycle with 0xDEAD_BEEF → mem_req high one cycle with mem_wr=0 and mem_wstrb=0; ld_data_ok=1 and ld_rdata=0xDEAD_BEEF three cycles after ld_req.
- WB stall: same as above, but hold ld_fire=0 for 4 cycles → ld_data_ok and ld_rdata stay stable for 4 cycles; no second mem_req; IDLE after ld_fire.
- Arbitration: ld_req and st_req (addr 0x20, wstrb 4'h3, data 0x1234) together → load issued first; store issued after ld_fire with mem_size=1; st_accept pulses exactly in the store's addr_ok cycle.
- Flush while waiting: flush in the WAIT_DATA cycle of a load, data_ok 2 cycles later with 0x5555_5555 → ld_data_ok never asserts; a new load issued afterwards returns its own data.
- Flush before acceptance: flush while in REQ with addr_ok delayed 3 cycles → mem_req stays high until addr_ok; the response is discarded.
- Reset in HOLD: assert reset → next cycle ld_data_ok=0, ld_rdata=0, mem_req=0, st_accept=0.

Source files
------------

// File: rtl/mem_dsram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_dsram_ctrl                                                 |
// | Brief   : Data-SRAM port sequencer shared by MEM-stage loads and         |
// |           EX-stage stores; one outstanding access, flush-aware.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_dsram_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // load side (MEM stage)
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_fire,
  output logic              ld_data_ok,
  output logic [DATA_W-1:0] ld_rdata,
  // store side (EX stage)
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_wstrb,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_accept,
  // pipeline flush
  input  logic              flush,
  // memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_HOLD      = 3'd3,
    S_DISCARD   = 3'd4
  } state_t;

  state_t              state_q;
  logic                kill_q;
  logic                mem_req_q;
  logic                mem_wr_q;
  logic [1:0]          mem_size_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [3:0]          mem_wstrb_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                ld_data_ok_q;
  logic [DATA_W-1:0]   ld_rdata_q;
  logic [1:0]          st_size_d;

  // Store access size derived from the byte-enable pattern.
  always_comb begin
    st_size_d = 2'b00;
    if (st_wstrb == 4'hF) begin
      st_size_d = 2'b10;
    end else if ((st_wstrb == 4'h3) || (st_wstrb == 4'hC)) begin
      st_size_d = 2'b01;
    end
  end

  // Transaction sequencer: arbitration, request hold, response capture/drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= 2'b00;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= '0;
      ld_data_ok_q <= 1'b0;
      ld_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The load in MEM is older than the store in EX, so it wins.
          if (!flush) begin
            if (ld_req) begin
              state_q     <= S_REQ;
              kill_q      <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_wr_q    <= 1'b0;
              mem_size_q  <= ld_size;
              mem_addr_q  <= ld_addr;
              mem_wstrb_q <= 4'h0;
              mem_wdata_q <= '0;
            end else if (st_req) begin
              state_q     <= S_REQ;
              kill_q      <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_wr_q    <= 1'b1;
              mem_size_q  <= st_size_d;
              mem_addr_q  <= st_addr;
              mem_wstrb_q <= st_wstrb;
              mem_wdata_q <= st_wdata;
            end
          end
        end
        S_REQ: begin
          // The request stays up until accepted; a flushed load is only
          // remembered so its response can be dropped later.
          if (mem_addr_ok) begin
            mem_req_q <= 1'b0;
            kill_q    <= 1'b0;
            if (!mem_wr_q && (kill_q || flush)) begin
              state_q <= S_DISCARD;
            end else begin
              state_q <= S_WAIT_DATA;
            end
          end else if (!mem_wr_q && flush) begin
            kill_q <= 1'b1;
          end
        end
        S_WAIT_DATA: begin
          if (mem_wr_q) begin
            // An accepted store is committed; flush no longer matters.
            if (mem_data_ok) begin
              state_q <= S_IDLE;
            end
          end else if (mem_data_ok) begin
            if (flush) begin
              state_q <= S_IDLE;
            end else begin
              ld_rdata_q   <= mem_rdata;
              ld_data_ok_q <= 1'b1;
              state_q      <= S_HOLD;
            end
          end else if (flush) begin
            state_q <= S_DISCARD;
          end
        end
        S_HOLD: begin
          // Data is held for MEM until it advances or is flushed.
          if (ld_fire || flush) begin
            ld_data_ok_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (mem_data_ok) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign st_accept  = (state_q == S_REQ) && mem_addr_ok && mem_wr_q;
  assign ld_data_ok = ld_data_ok_q;
  assign ld_rdata   = ld_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dsram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_dsram_ctrl                                              |
// | Brief   : Scoreboard bench for mem_dsram_ctrl.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_dsram_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_req, ld_fire, ld_data_ok;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic [DATA_W-1:0] ld_rdata;
  logic              st_req, st_accept;
  logic [ADDR_W-1:0] st_addr;
  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic              flush;
  logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  logic [31:0] ld_exp_q[$];
  st_t         st_exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_req = 0;
  int          n_st_acc = 0;
  logic        ok_prev = 1'b0;
  logic [31:0] ld_e;
  st_t         st_e;

  mem_dsram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_fire(ld_fire),
    .ld_data_ok(ld_data_ok), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wstrb(st_wstrb), .st_wdata(st_wdata),
    .st_accept(st_accept), .flush(flush),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops expected load data on each new ld_data_ok and
  // expected store fields on each st_accept pulse.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (mem_req) n_req++;
      if (ld_data_ok && !ok_prev) begin
        if (ld_exp_q.size() == 0) begin
          chk("ld_unexpected", 64'd1, 64'd0);
        end else begin
          ld_e = ld_exp_q.pop_front();
          chk("sb_ld_rdata", {32'd0, ld_rdata}, {32'd0, ld_e});
        end
      end
      if (st_accept) begin
        n_st_acc++;
        chk("st_acc_aok", {63'd0, mem_addr_ok}, 64'd1);
        if (st_exp_q.size() == 0) begin
          chk("st_unexpected", 64'd1, 64'd0);
        end else begin
          st_e = st_exp_q.pop_front();
          chk("sb_st_addr",  {32'd0, mem_addr},  {32'd0, st_e.addr});
          chk("sb_st_wstrb", {60'd0, mem_wstrb}, {60'd0, st_e.wstrb});
          chk("sb_st_wdata", {32'd0, mem_wdata}, {32'd0, st_e.data});
          chk("sb_st_size",  {62'd0, mem_size},  {62'd0, st_e.size});
          chk("sb_st_wr",    {63'd0, mem_wr},    64'd1);
        end
      end
    end
    ok_prev = ld_data_ok;
  end

  // Load with addr_ok in the first REQ cycle and data_ok the cycle after.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data, input int stall, input bit fire);
    int r0;
    r0 = n_req;
    ld_req = 1'b1; ld_addr = addr; ld_size = size;
    tick();
    chk("ld_req_rise", {63'd0, mem_req}, 64'd1);
    chk("ld_wr",       {63'd0, mem_wr}, 64'd0);
    chk("ld_wstrb",    {60'd0, mem_wstrb}, 64'd0);
    chk("ld_addr",     {32'd0, mem_addr}, {32'd0, addr});
    chk("ld_size",     {62'd0, mem_size}, {62'd0, size});
    mem_addr_ok = 1'b1;
    tick();
    chk("ld_req_fall", {63'd0, mem_req}, 64'd0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = data;
    ld_exp_q.push_back(data);
    tick();
    mem_data_ok = 1'b0; mem_rdata = '0;
    chk("ld_ok", {63'd0, ld_data_ok}, 64'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("ld_ok_hold",    {63'd0, ld_data_ok}, 64'd1);
      chk("ld_rdata_hold", {32'd0, ld_rdata}, {32'd0, data});
    end
    if (fire) begin
      ld_fire = 1'b1;
      tick();
      ld_fire = 1'b0; ld_req = 1'b0;
      chk("ld_ok_clear", {63'd0, ld_data_ok}, 64'd0);
      chk("ld_one_req", 64'(n_req - r0), 64'd1);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] data, input logic [1:0] esize);
    int a0;
    st_req = 1'b1; st_addr = addr; st_wstrb = wstrb; st_wdata = data;
    st_exp_q.push_back('{addr: addr, wstrb: wstrb, data: data, size: esize});
    tick();
    chk("st_req_rise", {63'd0, mem_req}, 64'd1);
    chk("st_wr",       {63'd0, mem_wr}, 64'd1);
    a0 = n_st_acc;
    mem_addr_ok = 1'b1;
    tick();
    chk("st_acc_cnt", 64'(n_st_acc - a0), 64'd1);
    st_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick();
    mem_data_ok = 1'b0;
    chk("st_idle_req", {63'd0, mem_req}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ld_req = 0; ld_fire = 0; ld_addr = '0; ld_size = 0;
    st_req = 0; st_addr = '0; st_wstrb = 0; st_wdata = '0; flush = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_req",   {63'd0, mem_req}, 64'd0);
    chk("rst_ok",    {63'd0, ld_data_ok}, 64'd0);
    chk("rst_rdata", {32'd0, ld_rdata}, 64'd0);
    chk("rst_acc",   {63'd0, st_accept}, 64'd0);
    chk("rst_addr",  {32'd0, mem_addr}, 64'd0);
    reset = 1'b0;
    tick();

    // Plain load, then WB stall of 4 cycles.
    do_load(32'h1C00_0010, 2'd2, 32'hDEAD_BEEF, 0, 1'b1);
    tick();
    do_load(32'h1C00_0014, 2'd2, 32'hA5A5_0001, 4, 1'b1);
    tick();

    // Arbitration: load and store together; load first, store after fire.
    st_req = 1'b1; st_addr = 32'h20; st_wstrb = 4'h3; st_wdata = 32'h1234;
    do_load(32'h1C00_0018, 2'd1, 32'h0BAD_F00D, 0, 1'b1);
    do_store(32'h20, 4'h3, 32'h1234, 2'd1);
    tick();

    // Flush in WAIT_DATA; data_ok two cycles later is dropped.
    ld_req = 1'b1; ld_addr = 32'h1C00_0030; ld_size = 2'd2;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; flush = 1'b1; ld_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("fw_ok0", {63'd0, ld_data_ok}, 64'd0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    chk("fw_ok1", {63'd0, ld_data_ok}, 64'd0);
    tick();
    mem_data_ok = 1'b0; mem_rdata = '0;
    chk("fw_ok2", {63'd0, ld_data_ok}, 64'd0);
    tick();
    chk("fw_ok3", {63'd0, ld_data_ok}, 64'd0);
    chk("fw_req", {63'd0, mem_req}, 64'd0);
    do_load(32'h1C00_0034, 2'd2, 32'h1111_2222, 0, 1'b1);
    tick();

    // Flush in REQ with addr_ok delayed 3 cycles: request held, response dropped.
    ld_req = 1'b1; ld_addr = 32'h1C00_0040; ld_size = 2'd0;
    tick();
    flush = 1'b1; ld_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("fr_req1", {63'd0, mem_req}, 64'd1);
    tick();
    chk("fr_req2", {63'd0, mem_req}, 64'd1);
    chk("fr_addr", {32'd0, mem_addr}, 64'h1C00_0040);
    tick();
    chk("fr_req3", {63'd0, mem_req}, 64'd1);
    mem_addr_ok = 1'b1;
    tick();
    chk("fr_req4", {63'd0, mem_req}, 64'd0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_data_ok = 1'b0; mem_rdata = '0;
    chk("fr_ok0", {63'd0, ld_data_ok}, 64'd0);
    tick();
    chk("fr_ok1", {63'd0, ld_data_ok}, 64'd0);

    // Flush in IDLE grants nothing.
    ld_req = 1'b1; flush = 1'b1;
    tick();
    chk("fi_req", {63'd0, mem_req}, 64'd0);
    ld_req = 1'b0; flush = 1'b0;
    tick();

    // Reset while holding load data.
    do_load(32'h1C00_0050, 2'd2, 32'h3C3C_C3C3, 1, 1'b0);
    reset = 1'b1; ld_req = 1'b0;
    tick();
    chk("rh_ok",    {63'd0, ld_data_ok}, 64'd0);
    chk("rh_rdata", {32'd0, ld_rdata}, 64'd0);
    chk("rh_req",   {63'd0, mem_req}, 64'd0);
    chk("rh_acc",   {63'd0, st_accept}, 64'd0);
    reset = 1'b0;
    tick();

    // Store size encodings for full-word and single-byte strobes.
    do_store(32'h1C00_0100, 4'hF, 32'hCAFE_F00D, 2'd2);
    tick();
    do_store(32'h1C00_0106, 4'h4, 32'h00AB_0000, 2'd0);
    tick();

    chk("ld_q_empty", 64'(ld_exp_q.size()), 64'd0);
    chk("st_q_empty", 64'(st_exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
